run_ctrl: RTL and testbench

RUN_CTRL -- requirements
Module: run_ctrl

---
 rtl/run_ctrl_pkg.sv | 24 ++
 rtl/run_ctrl_halt_decode.sv | 15 +
 rtl/run_ctrl.sv | 143 ++++++++++++++
 tb/tb_run_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_ctrl_pkg.sv
// Shared types and instruction constants for the run controller.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_STEP    = 2'd2,
    ST_HALTED  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE         = 3'd0,
    CAUSE_ECALL        = 3'd1,
    CAUSE_INVALID      = 3'd2,
    CAUSE_BRANCH_LIMIT = 3'd3,
    CAUSE_CYCLE_LIMIT  = 3'd4,
    CAUSE_USER         = 3'd5
  } halt_cause_t;

  localparam logic [6:0]  OPC_BRANCH    = 7'b1100011;
  localparam logic [31:0] INSTR_ECALL   = 32'h00000073;
  localparam logic [31:0] INSTR_INVALID = 32'hFFFFFFFF;

endpackage

// File: rtl/run_ctrl_halt_decode.sv
// Classifies the core's current instruction word for the run controller.
module halt_decode
  import run_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic        is_ecall,
  output logic        is_invalid,
  output logic        is_branch
);

  assign is_ecall   = (instr == INSTR_ECALL);
  assign is_invalid = (instr == INSTR_INVALID);
  assign is_branch  = (instr[6:0] == OPC_BRANCH);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: gates the core's architectural writes, counts retired
// instructions and branches, and stops on halting instructions, limits or
// user requests. The core is held in reset while the controller is idle.
module run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int MAX_CYCLES   = 1000,
  parameter int MAX_BRANCHES = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic        resume,
  input  logic        halt_req,
  input  logic [31:0] instr,
  output logic        cpu_rst,
  output logic        cpu_en,
  output logic        halted,
  output logic [2:0]  halt_cause,
  output logic [31:0] cycle_cnt,
  output logic [15:0] branch_cnt
);

  localparam logic [31:0] CYCLE_LIMIT  = 32'(MAX_CYCLES);
  localparam logic [15:0] BRANCH_LIMIT = 16'(MAX_BRANCHES);

  state_t      state;
  state_t      state_next;
  halt_cause_t cause_q;
  halt_cause_t cause_next;
  halt_cause_t blocked_cause;
  logic [31:0] cycle_q;
  logic [15:0] branch_q;
  logic        cpu_rst_q;
  logic        clear_cnt;
  logic        is_ecall;
  logic        is_invalid;
  logic        is_branch;
  logic        active;
  logic        at_branch_limit;
  logic        at_cycle_limit;
  logic        blocked;

  halt_decode u_halt_decode (
    .instr      (instr),
    .is_ecall   (is_ecall),
    .is_invalid (is_invalid),
    .is_branch  (is_branch)
  );

  // An instruction that would halt or exceed a limit is blocked: it never
  // retires, so the PC stays on it and the cause can be reported exactly.
  always_comb begin
    active          = (state == ST_RUN) || (state == ST_STEP);
    at_branch_limit = is_branch && (branch_q == BRANCH_LIMIT);
    at_cycle_limit  = (cycle_q == CYCLE_LIMIT);
    blocked         = is_ecall || is_invalid || at_branch_limit || at_cycle_limit;
    cpu_en          = active && !blocked && !rst;
    if (is_ecall)             blocked_cause = CAUSE_ECALL;
    else if (is_invalid)      blocked_cause = CAUSE_INVALID;
    else if (at_branch_limit) blocked_cause = CAUSE_BRANCH_LIMIT;
    else                      blocked_cause = CAUSE_CYCLE_LIMIT;
  end

  // Next-state logic; the halt cause and counter clearing follow the transition.
  always_comb begin
    state_next = state;
    cause_next = cause_q;
    clear_cnt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start || step) begin
          state_next = start ? ST_RUN : ST_STEP;
          cause_next = CAUSE_NONE;
          clear_cnt  = 1'b1;
        end
      end
      ST_RUN: begin
        if (blocked) begin
          state_next = ST_HALTED;
          cause_next = blocked_cause;
        end else if (halt_req) begin
          state_next = ST_HALTED;
          cause_next = CAUSE_USER;
        end
      end
      ST_STEP: begin
        state_next = ST_HALTED;
        cause_next = blocked ? blocked_cause : CAUSE_USER;
      end
      ST_HALTED: begin
        if (start) begin
          state_next = ST_IDLE;
          cause_next = CAUSE_NONE;
          clear_cnt  = 1'b1;
        end else if (cause_q == CAUSE_USER && step) begin
          state_next = ST_STEP;
          cause_next = CAUSE_NONE;
        end else if (cause_q == CAUSE_USER && resume) begin
          state_next = ST_RUN;
          cause_next = CAUSE_NONE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cause_next = CAUSE_NONE;
        clear_cnt  = 1'b1;
      end
    endcase
  end

  // State, cause and core-reset registers; core reset tracks entry into idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cause_q   <= CAUSE_NONE;
      cpu_rst_q <= 1'b1;
    end else begin
      state     <= state_next;
      cause_q   <= cause_next;
      cpu_rst_q <= (state_next == ST_IDLE);
    end
  end

  // Retirement counters; the blocking logic keeps them from passing their limits.
  always_ff @(posedge clk) begin
    if (rst || clear_cnt) begin
      cycle_q  <= '0;
      branch_q <= '0;
    end else if (cpu_en) begin
      cycle_q <= cycle_q + 32'd1;
      if (is_branch) branch_q <= branch_q + 16'd1;
    end
  end

  assign cpu_rst    = cpu_rst_q;
  assign halted     = (state == ST_HALTED);
  assign halt_cause = cause_q;
  assign cycle_cnt  = cycle_q;
  assign branch_cnt = branch_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Self-checking bench for run_ctrl: two instances (default cycle limit and a
// cycle limit of 8) share control pulses, each fetching from the program by
// its own reference-model PC.
module tb_run_ctrl;

  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;
  localparam int C_NONE = 0, C_ECALL = 1, C_INVALID = 2, C_BRLIM = 3, C_CYCLIM = 4, C_USER = 5;
  localparam int MAXB = 20;
  localparam logic [31:0] W_ECALL   = 32'h00000073;
  localparam logic [31:0] W_INVALID = 32'hFFFFFFFF;
  localparam logic [31:0] W_ALU     = 32'h00100093;
  localparam logic [31:0] W_BRANCH  = 32'h00208463;

  typedef struct {
    int st;
    int cyc;
    int br;
    int cause;
    int pc;
  } model_t;

  logic        clk = 1'b0;
  logic        rst, start, step, resume, halt_req;
  logic [31:0] instr_a, instr_b;
  logic        cpu_rst_a, cpu_en_a, halted_a, cpu_rst_b, cpu_en_b, halted_b;
  logic [2:0]  halt_cause_a, halt_cause_b;
  logic [31:0] cycle_cnt_a, cycle_cnt_b;
  logic [15:0] branch_cnt_a, branch_cnt_b;

  model_t      m [2];
  logic [31:0] prog [64];
  logic [31:0] t_instr [2];
  logic        o_en [2];
  logic        e_en [2];
  logic        o_rst [2];
  logic        o_halted [2];
  logic [2:0]  o_cause [2];
  logic [31:0] o_cyc [2];
  logic [15:0] o_br [2];
  int checks = 0;
  int failures = 0;

  run_ctrl #(.MAX_CYCLES(1000), .MAX_BRANCHES(MAXB)) dut_a (
    .clk(clk), .rst(rst), .start(start), .step(step), .resume(resume),
    .halt_req(halt_req), .instr(instr_a), .cpu_rst(cpu_rst_a), .cpu_en(cpu_en_a),
    .halted(halted_a), .halt_cause(halt_cause_a), .cycle_cnt(cycle_cnt_a),
    .branch_cnt(branch_cnt_a)
  );

  run_ctrl #(.MAX_CYCLES(8), .MAX_BRANCHES(MAXB)) dut_b (
    .clk(clk), .rst(rst), .start(start), .step(step), .resume(resume),
    .halt_req(halt_req), .instr(instr_b), .cpu_rst(cpu_rst_b), .cpu_en(cpu_en_b),
    .halted(halted_b), .halt_cause(halt_cause_b), .cycle_cnt(cycle_cnt_b),
    .branch_cnt(branch_cnt_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic int max_c(input int k);
    return (k == 0) ? 1000 : 8;
  endfunction

  function automatic bit is_br(input logic [31:0] w);
    return w[6:0] == 7'b1100011;
  endfunction

  // An instruction retires when running and it is neither halting nor over a limit.
  function automatic bit model_en(input model_t s, input bit r, input logic [31:0] w, input int k);
    if (r) return 1'b0;
    if (s.st != M_RUN && s.st != M_STEP) return 1'b0;
    if (w == W_ECALL || w == W_INVALID) return 1'b0;
    if (is_br(w) && s.br >= MAXB) return 1'b0;
    if (s.cyc >= max_c(k)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic model_t model_next(input model_t s, input bit r, input bit go, input bit stp,
                                        input bit res, input bit hr, input logic [31:0] w, input int k);
    model_t n;
    bit en;
    n  = s;
    en = model_en(s, r, w, k);
    if (r) begin
      n.st = M_IDLE; n.cyc = 0; n.br = 0; n.cause = C_NONE; n.pc = 0;
      return n;
    end
    if (en) begin
      n.cyc = n.cyc + 1;
      if (is_br(w)) n.br = n.br + 1;
      n.pc = n.pc + 1;
    end
    case (s.st)
      M_IDLE: if (go || stp) begin
        n.st = go ? M_RUN : M_STEP; n.cyc = 0; n.br = 0; n.cause = C_NONE; n.pc = 0;
      end
      M_RUN, M_STEP: begin
        if (!en) begin
          n.st = M_HALT;
          if (w == W_ECALL) n.cause = C_ECALL;
          else if (w == W_INVALID) n.cause = C_INVALID;
          else if (is_br(w) && s.br >= MAXB) n.cause = C_BRLIM;
          else n.cause = C_CYCLIM;
        end else if (s.st == M_STEP || hr) begin
          n.st = M_HALT; n.cause = C_USER;
        end
      end
      M_HALT: begin
        if (go) begin
          n.st = M_IDLE; n.cyc = 0; n.br = 0; n.cause = C_NONE; n.pc = 0;
        end else if (s.cause == C_USER && stp) begin
          n.st = M_STEP; n.cause = C_NONE;
        end else if (s.cause == C_USER && res) begin
          n.st = M_RUN; n.cause = C_NONE;
        end
      end
      default: n.st = M_IDLE;
    endcase
    return n;
  endfunction

  // One clock cycle: drive pulses, capture cpu_en before the edge, advance the
  // models, and snapshot the registered outputs at the following falling edge.
  task automatic tick(input bit r, input bit go, input bit stp, input bit res, input bit hr);
    rst = r; start = go; step = stp; resume = res; halt_req = hr;
    instr_a = prog[6'(m[0].pc % 64)];
    instr_b = prog[6'(m[1].pc % 64)];
    t_instr[0] = instr_a;
    t_instr[1] = instr_b;
    #1;
    o_en[0] = cpu_en_a;
    o_en[1] = cpu_en_b;
    for (int k = 0; k < 2; k++) begin
      e_en[k] = model_en(m[k], r, t_instr[k], k);
      m[k]    = model_next(m[k], r, go, stp, res, hr, t_instr[k], k);
    end
    @(posedge clk);
    #1;
    rst = 1'b0; start = 1'b0; step = 1'b0; resume = 1'b0; halt_req = 1'b0;
    @(negedge clk);
    o_rst[0] = cpu_rst_a;       o_rst[1] = cpu_rst_b;
    o_halted[0] = halted_a;     o_halted[1] = halted_b;
    o_cause[0] = halt_cause_a;  o_cause[1] = halt_cause_b;
    o_cyc[0] = cycle_cnt_a;     o_cyc[1] = cycle_cnt_b;
    o_br[0] = branch_cnt_a;     o_br[1] = branch_cnt_b;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic fill_prog(input logic [31:0] w);
    for (int i = 0; i < 64; i++) prog[i] = w;
  endtask

  task automatic test_reset();
    fill_prog(W_ALU);
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (o_rst[k] !== 1'b1) begin failures++; $display("[TB] FAIL reset_cpu_rst dut=%0d actual=%b required=1", k, o_rst[k]); end
      checks++; if (o_en[k] !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_en dut=%0d actual=%b required=0", k, o_en[k]); end
      checks++; if (o_halted[k] !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted dut=%0d actual=%b required=0", k, o_halted[k]); end
      checks++; if (o_cause[k] !== 3'd0) begin failures++; $display("[TB] FAIL reset_cause dut=%0d actual=%0d required=0", k, o_cause[k]); end
      checks++; if (o_cyc[k] !== 32'd0 || o_br[k] !== 16'd0) begin failures++; $display("[TB] FAIL reset_counters dut=%0d actual=%0d/%0d required=0/0", k, o_cyc[k], o_br[k]); end
    end
  endtask

  task automatic test_ecall();
    fill_prog(W_ALU);
    prog[5] = W_ECALL;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (t_instr[0] == W_ECALL) begin
        checks++; if (o_en[0] !== 1'b0) begin failures++; $display("[TB] FAIL ecall_cpu_en cycle=%0d actual=%b required=0", i, o_en[0]); end
      end
    end
    checks++; if (o_cyc[0] !== 32'd5) begin failures++; $display("[TB] FAIL ecall_cycle_cnt actual=%0d required=5", o_cyc[0]); end
    checks++; if (o_cause[0] !== 3'd1) begin failures++; $display("[TB] FAIL ecall_cause actual=%0d required=1", o_cause[0]); end
    checks++; if (o_halted[0] !== 1'b1) begin failures++; $display("[TB] FAIL ecall_halted actual=%b required=1", o_halted[0]); end
  endtask

  task automatic test_branch_limit();
    int en_count;
    en_count = 0;
    fill_prog(W_BRANCH);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      if (o_en[0] === 1'b1) en_count++;
      if (i == 20) begin
        checks++; if (o_en[0] !== 1'b0) begin failures++; $display("[TB] FAIL branch21_cpu_en actual=%b required=0", o_en[0]); end
      end
    end
    checks++; if (en_count != 20) begin failures++; $display("[TB] FAIL branch_retired actual=%0d required=20", en_count); end
    checks++; if (o_br[0] !== 16'd20) begin failures++; $display("[TB] FAIL branch_cnt actual=%0d required=20", o_br[0]); end
    checks++; if (o_cause[0] !== 3'd3 || o_halted[0] !== 1'b1) begin failures++; $display("[TB] FAIL branch_cause actual=%0d/%b required=3/1", o_cause[0], o_halted[0]); end
    checks++; if (o_cause[1] !== 3'd4 || o_br[1] !== 16'd8) begin failures++; $display("[TB] FAIL branch_small_limit actual=%0d/%0d required=4/8", o_cause[1], o_br[1]); end
  endtask

  task automatic test_cycle_limit();
    fill_prog(W_ALU);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(15);
    checks++; if (o_cyc[1] !== 32'd8) begin failures++; $display("[TB] FAIL cyclim_cycle_cnt actual=%0d required=8", o_cyc[1]); end
    checks++; if (o_cause[1] !== 3'd4 || o_halted[1] !== 1'b1) begin failures++; $display("[TB] FAIL cyclim_cause actual=%0d/%b required=4/1", o_cause[1], o_halted[1]); end
    checks++; if (o_cyc[0] !== 32'd15 || o_halted[0] !== 1'b0) begin failures++; $display("[TB] FAIL cyclim_big_limit actual=%0d/%b required=15/0", o_cyc[0], o_halted[0]); end
  endtask

  task automatic test_step_resume();
    fill_prog(W_ALU);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(3);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_cyc[0] !== 32'd4 || o_halted[0] !== 1'b1 || o_cause[0] !== 3'd5) begin failures++; $display("[TB] FAIL user_halt actual=%0d/%b/%0d required=4/1/5", o_cyc[0], o_halted[0], o_cause[0]); end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++; if (o_halted[0] !== 1'b0 || o_cyc[0] !== 32'd4) begin failures++; $display("[TB] FAIL step_enter actual=%b/%0d required=0/4", o_halted[0], o_cyc[0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_cyc[0] !== 32'd5 || o_halted[0] !== 1'b1 || o_cause[0] !== 3'd5) begin failures++; $display("[TB] FAIL step1 actual=%0d/%b/%0d required=5/1/5", o_cyc[0], o_halted[0], o_cause[0]); end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_cyc[0] !== 32'd6 || o_halted[0] !== 1'b1) begin failures++; $display("[TB] FAIL step2 actual=%0d/%b required=6/1", o_cyc[0], o_halted[0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle_ticks(3);
    checks++; if (o_cyc[0] !== 32'd9 || o_halted[0] !== 1'b0) begin failures++; $display("[TB] FAIL resume_run actual=%0d/%b required=9/0", o_cyc[0], o_halted[0]); end
  endtask

  task automatic test_simultaneous();
    fill_prog(W_ALU);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle_ticks(2);
    checks++; if (o_cyc[0] !== 32'd2 || o_halted[0] !== 1'b1 || o_cause[0] !== 3'd5) begin failures++; $display("[TB] FAIL step_beats_resume actual=%0d/%b/%0d required=2/1/5", o_cyc[0], o_halted[0], o_cause[0]); end
    prog[8] = W_INVALID;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(10);
    checks++; if (o_cause[1] !== 3'd2 || o_cyc[1] !== 32'd8) begin failures++; $display("[TB] FAIL invalid_over_cyclim actual=%0d/%0d required=2/8", o_cause[1], o_cyc[1]); end
    prog[8] = W_ECALL;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(10);
    checks++; if (o_cause[1] !== 3'd1 || o_cyc[1] !== 32'd8) begin failures++; $display("[TB] FAIL ecall_over_cyclim actual=%0d/%0d required=1/8", o_cause[1], o_cyc[1]); end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (o_halted[1] !== 1'b1 || o_cause[1] !== 3'd1 || o_cyc[1] !== 32'd8) begin failures++; $display("[TB] FAIL nonuser_ignored actual=%b/%0d/%0d required=1/1/8", o_halted[1], o_cause[1], o_cyc[1]); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (o_rst[1] !== 1'b1 || o_halted[1] !== 1'b0 || o_cyc[1] !== 32'd0) begin failures++; $display("[TB] FAIL start_from_halt actual=%b/%b/%0d required=1/0/0", o_rst[1], o_halted[1], o_cyc[1]); end
  endtask

  task automatic test_reset_midrun();
    fill_prog(W_BRANCH);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(4);
    checks++; if (o_br[0] !== 16'd4) begin failures++; $display("[TB] FAIL midrun_pre actual=%0d required=4", o_br[0]); end
    tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (o_en[0] !== 1'b0) begin failures++; $display("[TB] FAIL midrun_en_in_rst actual=%b required=0", o_en[0]); end
    checks++; if (o_rst[0] !== 1'b1 || o_halted[0] !== 1'b0 || o_cause[0] !== 3'd0) begin failures++; $display("[TB] FAIL midrun_flags actual=%b/%b/%0d required=1/0/0", o_rst[0], o_halted[0], o_cause[0]); end
    checks++; if (o_cyc[0] !== 32'd0 || o_br[0] !== 16'd0) begin failures++; $display("[TB] FAIL midrun_counters actual=%0d/%0d required=0/0", o_cyc[0], o_br[0]); end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_en[0] !== 1'b0 || o_rst[0] !== 1'b1) begin failures++; $display("[TB] FAIL idle_outputs actual=%b/%b required=0/1", o_en[0], o_rst[0]); end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_ticks(3);
    checks++; if (o_cyc[0] !== 32'd3 || o_rst[0] !== 1'b0 || o_halted[0] !== 1'b0) begin failures++; $display("[TB] FAIL rerun actual=%0d/%b/%b required=3/0/0", o_cyc[0], o_rst[0], o_halted[0]); end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (o_cyc[0] !== 32'd0 || o_rst[0] !== 1'b1 || o_halted[0] !== 1'b0) begin failures++; $display("[TB] FAIL midstep_reset actual=%0d/%b/%b required=0/1/0", o_cyc[0], o_rst[0], o_halted[0]); end
  endtask

  task automatic test_random();
    logic [31:0] rv;
    int r;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc % 200 == 0) begin
        for (int i = 0; i < 64; i++) begin
          rv = $urandom();
          r  = $urandom_range(0, 99);
          if (r < 3) prog[i] = W_ECALL;
          else if (r < 6) prog[i] = W_INVALID;
          else if (r < 35) prog[i] = {rv[31:7], 7'b1100011};
          else prog[i] = {rv[31:7], 7'b0010011};
        end
      end
      tick($urandom_range(0, 99) < 1, $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 10,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 7);
      for (int k = 0; k < 2; k++) begin
        checks++; if (o_en[k] !== e_en[k]) begin failures++; $display("[TB] FAIL rand_cpu_en dut=%0d cycle=%0d actual=%b required=%b", k, cyc, o_en[k], e_en[k]); end
        checks++; if (o_rst[k] !== (m[k].st == M_IDLE)) begin failures++; $display("[TB] FAIL rand_cpu_rst dut=%0d cycle=%0d actual=%b required=%b", k, cyc, o_rst[k], m[k].st == M_IDLE); end
        checks++; if (o_halted[k] !== (m[k].st == M_HALT)) begin failures++; $display("[TB] FAIL rand_halted dut=%0d cycle=%0d actual=%b required=%b", k, cyc, o_halted[k], m[k].st == M_HALT); end
        checks++; if (o_cyc[k] !== 32'(m[k].cyc) || o_br[k] !== 16'(m[k].br)) begin failures++; $display("[TB] FAIL rand_counters dut=%0d cycle=%0d actual=%0d/%0d required=%0d/%0d", k, cyc, o_cyc[k], o_br[k], m[k].cyc, m[k].br); end
        if (m[k].st == M_HALT) begin
          checks++; if (o_cause[k] !== 3'(m[k].cause)) begin failures++; $display("[TB] FAIL rand_cause dut=%0d cycle=%0d actual=%0d required=%0d", k, cyc, o_cause[k], m[k].cause); end
        end
      end
    end
  endtask

  // Scenario sequence followed by the summary line.
  initial begin
    rst = 1'b1; start = 1'b0; step = 1'b0; resume = 1'b0; halt_req = 1'b0;
    instr_a = W_ALU; instr_b = W_ALU;
    for (int k = 0; k < 2; k++) m[k] = '{st: M_IDLE, cyc: 0, br: 0, cause: C_NONE, pc: 0};
    fill_prog(W_ALU);
    @(negedge clk);
    test_reset();
    test_ecall();
    test_branch_limit();
    test_cycle_limit();
    test_step_resume();
    test_simultaneous();
    test_reset_midrun();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
